// File: rtl/mult_seq_if.sv
// Handshake and data bundle for the sequential multiplier.
// The master drives start/a/b; the slave (multiplier) returns busy/done/p.
interface mult_seq_if #(
  parameter int W = 4
);
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;

  modport master (output start, a, b, input busy, done, p);
  modport slave  (input start, a, b, output busy, done, p);
endinterface

// File: rtl/mult_seq.sv
// Sequential shift-and-add multiplier: W iterations of one (W+1)-bit add, start/busy/done handshake.
// Latency W+1 edges start-to-done; MULT_SIGNED_EN selects two's-complement operands and product.
module mult_seq #(
  parameter int W = 4
) (
  input  logic      clk,
  input  logic      rst,
  mult_seq_if.slave bus
);
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q;
  logic [W-1:0]   mcand_q;
  logic [W-1:0]   mplier_q;
  logic [W:0]     acc_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;
  logic           done_q;
  logic [2*W-1:0] p_q;

  logic [W:0]     sum_d;
  logic [W:0]     acc_d;
  logic [W-1:0]   mplier_d;
  logic           last_d;

  // acc_q[W] always mirrors the extension of acc_q[W-1:0] (zero, or sign in signed
  // mode), so the whole register can feed the adder directly.
  always_comb begin
    last_d = (cnt_q == CW'(W - 1));
`ifdef MULT_SIGNED_EN
    if (!mplier_q[0]) begin
      sum_d = acc_q;
    end else if (last_d) begin
      sum_d = acc_q - {mcand_q[W-1], mcand_q};
    end else begin
      sum_d = acc_q + {mcand_q[W-1], mcand_q};
    end
    acc_d = {sum_d[W], sum_d[W:1]};
`else
    sum_d = acc_q + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_d = {1'b0, sum_d[W:1]};
`endif
    mplier_d = {sum_d[0], mplier_q[W-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      p_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            mcand_q  <= bus.a;
            mplier_q <= bus.b;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= CALC;
          end else begin
            state_q  <= IDLE;
          end
        end
        CALC: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + CW'(1);
          if (last_d) begin
            p_q     <= {acc_d[W-1:0], mplier_d};
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.p    = p_q;
endmodule

// File: tb/tb_mult_seq.sv
// Scoreboard bench for mult_seq: driver pushes expected products, a negedge monitor checks busy/done/p.
module tb_mult_seq;
  localparam int W  = 4;
  localparam int PW = 2 * W;

  logic clk = 1'b0;
  logic rst;

  mult_seq_if #(.W(W)) bus ();
  mult_seq #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] prod;
    int            k;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  logic [PW-1:0] held_p = '0;
  int            cur_k  = 0;
  bit            cur_vld = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [PW-1:0] model(logic [W-1:0] x, logic [W-1:0] y);
`ifdef MULT_SIGNED_EN
    longint sx;
    longint sy;
    sx = x[W-1] ? longint'(x) - (longint'(1) << W) : longint'(x);
    sy = y[W-1] ? longint'(y) - (longint'(1) << W) : longint'(y);
    return PW'(sx * sy);
`else
    return PW'(longint'(x) * longint'(y));
`endif
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Inputs change between edges; the model is updated only after that cycle's monitor sample.
  task automatic issue(logic [W-1:0] x, logic [W-1:0] y);
    int c;
    c = cyc;
    bus.a     = x;
    bus.b     = y;
    bus.start = 1'b1;
    @(negedge clk);
    #1;
    sb.push_back('{model(x, y), c + 1});
    cur_k   = c + 1;
    cur_vld = 1'b1;
  endtask

  task automatic run(logic [W-1:0] x, logic [W-1:0] y, bit mid);
    issue(x, y);
    tick;
    bus.start = 1'b0;
    tick;
    if (mid) begin
      bus.start = 1'b1;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
    end
    tick;
    bus.start = 1'b0;
    repeat (W - 1) tick;
  endtask

  always @(negedge clk) begin
    bit   eb;
    bit   ed;
    exp_t e;
    eb = cur_vld && (cyc >= cur_k) && (cyc <= cur_k + W - 1);
    ed = cur_vld && (cyc == cur_k + W);
    chk("busy", 64'(bus.busy), 64'(eb));
    chk("done", 64'(bus.done), 64'(ed));
    chk("busy_done_exclusive", 64'(bus.busy & bus.done), 64'd0);
    if (bus.done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending op at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("product", 64'(bus.p), 64'(e.prod));
        chk("latency", 64'(cyc - e.k), 64'(W));
        held_p = e.prod;
      end
    end else begin
      chk("p_hold", 64'(bus.p), 64'(held_p));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #1;
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_p",    64'(bus.p),    64'd0);
    tick;
    tick;
    rst = 1'b0;

    run(4'd5,  4'd2,  1'b0);
    run(4'd15, 4'd15, 1'b0);
    run(4'd0,  4'd9,  1'b0);
    run(4'd8,  4'd1,  1'b0);
    run(4'd8,  4'd7,  1'b0);
    run(4'd13, 4'd11, 1'b0);
    run(4'd7,  4'd15, 1'b0);

    // start during CALC must be ignored
    issue(4'd3, 4'd3);
    tick;
    bus.start = 1'b0;
    tick;
    bus.start = 1'b1;
    bus.a     = 4'd7;
    bus.b     = 4'd7;
    tick;
    bus.start = 1'b0;
    repeat (W - 1) tick;

    // start held high across two operations
    issue(4'd6, 4'd7);
    repeat (W + 1) tick;
    issue(4'd2, 4'd9);
    tick;
    bus.start = 1'b0;
    repeat (W) tick;

    // asynchronous reset between edges in the second CALC cycle
    issue(4'd9, 4'd11);
    tick;
    bus.start = 1'b0;
    tick;
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_p",    64'(bus.p),    64'd0);
    sb.delete();
    cur_vld = 1'b0;
    held_p  = '0;
    tick;
    rst = 1'b0;
    run(4'd4, 4'd4, 1'b0);

    for (int i = 0; i < 30; i++) begin
      run(W'($urandom), W'($urandom), bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) tick;
    end

    repeat (3) tick;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
